// File: rtl/button_event_classifier.sv
// button_event_classifier: turns a debounced button level into press, short, long, auto-repeat and double-click pulses.
module button_event_classifier #(
   parameter int CLK_FREQ_MHZ = 50,
   parameter int LONG_MS      = 1000,
   parameter int REPEAT_MS    = 200,
   parameter int DCLICK_MS    = 300
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_level,
   output logic       press_pulse,
   output logic       short_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       double_pulse,
   output logic       held,
   output logic [7:0] event_count
);
   localparam logic [31:0] LONG_TICKS   = 32'(LONG_MS * CLK_FREQ_MHZ * 1000);
   localparam logic [31:0] REPEAT_TICKS = 32'(REPEAT_MS * CLK_FREQ_MHZ * 1000);
   localparam logic [31:0] DCLICK_TICKS = 32'(DCLICK_MS * CLK_FREQ_MHZ * 1000);

   typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD, WAIT_DBL} state_t;

   state_t      state, state_n;
   logic        second, second_n;
   logic        btn_q, rise, fall, clr;
   logic [31:0] cnt;
   logic        press_n, short_n, long_n, rep_n, dbl_n;

   assign rise = btn_level & ~btn_q;
   assign fall = ~btn_level & btn_q;
   assign held = btn_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         second       <= 1'b0;
         btn_q        <= 1'b0;
         cnt          <= '0;
         press_pulse  <= 1'b0;
         short_pulse  <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         double_pulse <= 1'b0;
         event_count  <= '0;
      end else begin
         state        <= state_n;
         second       <= second_n;
         btn_q        <= btn_level;
         cnt          <= (clr || state == IDLE) ? '0 : cnt + 32'd1;
         press_pulse  <= press_n;
         short_pulse  <= short_n;
         long_pulse   <= long_n;
         repeat_pulse <= rep_n;
         double_pulse <= dbl_n;
         event_count  <= event_count + {7'd0, short_n | long_n | dbl_n};
      end
   end

   // Edges take priority over timeouts that land on the same clock.
   always_comb begin
      state_n  = state;
      second_n = second;
      clr      = 1'b0;
      press_n  = 1'b0;
      short_n  = 1'b0;
      long_n   = 1'b0;
      rep_n    = 1'b0;
      dbl_n    = 1'b0;
      case (state)
         IDLE: if (rise) begin
            state_n  = PRESSED;
            second_n = 1'b0;
            press_n  = 1'b1;
            clr      = 1'b1;
         end
         PRESSED: if (fall) begin
            state_n = second ? IDLE : WAIT_DBL;
            dbl_n   = second;
            clr     = 1'b1;
         end else if (btn_level && cnt == LONG_TICKS - 32'd1) begin
            state_n = LONG_HELD;
            long_n  = 1'b1;
            clr     = 1'b1;
         end
         LONG_HELD: if (fall) begin
            state_n = IDLE;
            clr     = 1'b1;
         end else if (cnt == REPEAT_TICKS - 32'd1) begin
            rep_n = 1'b1;
            clr   = 1'b1;
         end
         WAIT_DBL: if (rise) begin
            state_n  = PRESSED;
            second_n = 1'b1;
            press_n  = 1'b1;
            clr      = 1'b1;
         end else if (cnt == DCLICK_TICKS - 32'd1) begin
            state_n = IDLE;
            short_n = 1'b1;
            clr     = 1'b1;
         end
         default: begin
            state_n = IDLE;
            clr     = 1'b1;
         end
      endcase
   end
endmodule

// File: doc/button_event_classifier.md
BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 50, meaning clock frequency in MHz.
REQ-002 SHALL have parameter LONG_MS, default 1000, meaning hold time for a long press; LONG_TICKS = LONG_MS*CLK_FREQ_MHZ*1000.
REQ-003 SHALL have parameter REPEAT_MS, default 200, meaning auto-repeat period while held long; REPEAT_TICKS likewise.
REQ-004 SHALL have parameter DCLICK_MS, default 300, meaning max release gap for a double click; DCLICK_TICKS likewise.
REQ-005 SHALL have port clk, input, 1, rising-edge system clock.
REQ-006 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port btn_level, input, 1, debounced button level (1 = pressed), already synchronous to clk.
REQ-008 SHALL have port press_pulse, output, 1, one-cycle pulse on every press.
REQ-009 SHALL have port short_pulse, output, 1, one-cycle pulse for a confirmed single short click.
REQ-010 SHALL have port long_pulse, output, 1, one-cycle pulse when a hold reaches LONG_TICKS.
REQ-011 SHALL have port repeat_pulse, output, 1, one-cycle pulse every REPEAT_TICKS while in the long hold.
REQ-012 SHALL have port double_pulse, output, 1, one-cycle pulse for a double click.
REQ-013 SHALL have port held, output, 1, registered copy of btn_level.
REQ-014 SHALL have port event_count, output, 8, count of short, long and double events.

Function
REQ-015 SHALL keep btn_q, btn_level registered once; held = btn_q; rise = btn_level & ~btn_q; fall = ~btn_level & btn_q.
REQ-016 SHALL register all outputs; every pulse is high exactly one cycle, in the cycle after the deciding edge.
REQ-017 SHALL implement states IDLE, PRESSED, LONG_HELD, WAIT_DBL, plus a 1-bit second flag and one 32-bit tick counter.
REQ-018 SHALL clear the counter to 0 on every state entry; fire a timed event at the edge where counter == TICKS-1, exactly TICKS cycles after the entry edge.
REQ-019 IDLE: rise -> PRESSED, press_pulse, second=0.
REQ-020 PRESSED: counter reaches LONG_TICKS-1 while btn_level=1 -> LONG_HELD, long_pulse.
REQ-021 PRESSED: fall with second=0 -> WAIT_DBL, no pulse.
REQ-022 PRESSED: fall with second=1 -> IDLE, double_pulse.
REQ-023 WAIT_DBL: rise -> PRESSED, press_pulse, second=1.
REQ-024 WAIT_DBL: counter reaches DCLICK_TICKS-1 with no rise -> IDLE, short_pulse.
REQ-025 WAIT_DBL: rise on the same edge as timeout -> the rise wins; treat as second press, no short_pulse.
REQ-026 Second press reaching LONG_TICKS: long_pulse only; the first click is discarded and no short_pulse is issued.
REQ-027 LONG_HELD: repeat_pulse every REPEAT_TICKS cycles, counter cleared after each; fall -> IDLE, no short_pulse or repeat_pulse.
REQ-028 Fall and repeat timeout on the same edge in LONG_HELD: the fall wins; no repeat_pulse.
REQ-029 SHALL assert at most one of short_pulse, long_pulse or double_pulse per cycle.
REQ-030 SHALL increment event_count by 1 on each short_pulse, long_pulse or double_pulse (not press or repeat); wrap 255 -> 0.
REQ-031 All *_MS parameters SHALL be >= 1; other values are unsupported.

Reset
REQ-032 While rst_n=0 at a clk edge: state=IDLE, counter=0, second=0, btn_q=0; all pulses, held and event_count = 0.
REQ-033 Reset mid-operation SHALL abort any pending event with no pulse.
REQ-034 btn_level=1 at reset release SHALL be seen as a rise: press_pulse on the first edge after release.

Verification (CLK_FREQ_MHZ=1, LONG_MS=2, REPEAT_MS=1, DCLICK_MS=1: LONG=2000, REPEAT=1000, DCLICK=1000 ticks)
REQ-035 Short click: rise sampled at edge R, fall at R+100 -> press_pulse after R; short_pulse after R+1100; event_count=1.
REQ-036 Double click: high 50, low 500, high 50 -> two press_pulses; double_pulse one cycle after second fall; no short_pulse; event_count=1.
REQ-037 Timeout race: fall at F, next rise sampled exactly at F+1000 -> second press_pulse; no short_pulse.
REQ-038 Long hold: rise at R, hold 4500 cycles -> long_pulse after R+2000, repeat_pulse after R+3000 and R+4000; release gives no short_pulse; event_count=1.
REQ-039 Reset during LONG_HELD with button held -> all outputs 0 and event_count=0; release rst_n with btn_level=1 -> press_pulse on the next edge.
REQ-040 256 short clicks -> event_count wraps to 0; 257th -> 1.
